uart_rx_frontend: RTL and testbench

Serial receive front end between the board `rx` pin and the SoC's byte-level receive interface. It does the following:
- synchronises the asynchronous line;
- oversamples it and validates the start bit;
- deserialises 8N1 frames, LSB first;
- delivers each byte through a one-entry holding register with a valid/ready handshake.

It also reports framing and overrun errors as single-cycle pulses for the interrupt and status logic.

---
 rtl/uart_rx_frontend.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// UART receive front end: synchroniser, oversampled 8N1 deserialiser, one-entry holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_frontend #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int DIV_RAW = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCK_W   = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TCK_W-1:0] HALF_LAST = TCK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCK_W-1:0] FULL_LAST = TCK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BRK
`ifdef UART_RX_PARITY_EN
    , ST_PARITY
`endif
  } state_t;

  state_t           state_r;
  logic             sync1_r;
  logic             rxs_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic             tick_s;
  logic [TCK_W-1:0] tick_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             busy_r;
  logic             frame_err_r;
  logic             deliver_pend_r;
  logic [7:0]       out_data_r;
  logic             out_valid_r;
  logic             overrun_r;

`ifdef UART_RX_PARITY_EN
  logic par_bit_r;
  logic par_bad_r;
  logic parity_err_r;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  // Two-flop synchroniser on the raw line, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= rx;
      rxs_r   <= sync1_r;
    end
  end

  // Baud-tick divider, held at zero in IDLE so ticks align to the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= '0;
    end else if (state_r == ST_IDLE || div_cnt_r == DIV_LAST) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  assign tick_s = (state_r != ST_IDLE) && (div_cnt_r == DIV_LAST);

  // Frame state machine: start validation, data shift, stop check, break wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      tick_cnt_r     <= '0;
      bit_idx_r      <= 3'd0;
      shift_r        <= 8'h00;
      busy_r         <= 1'b0;
      frame_err_r    <= 1'b0;
      deliver_pend_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r      <= 1'b0;
      par_bad_r      <= 1'b0;
`endif
    end else begin
      frame_err_r    <= 1'b0;
      deliver_pend_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tick_cnt_r <= '0;
          if (!rxs_r) begin
            state_r <= ST_START;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_START: begin
          if (tick_s && tick_cnt_r == HALF_LAST) begin
            tick_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            if (rxs_r) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_DATA;
            end
          end else if (tick_s) begin
            tick_cnt_r <= tick_cnt_r + TCK_W'(1);
          end
        end
        ST_DATA: begin
          if (tick_s && tick_cnt_r == FULL_LAST) begin
            tick_cnt_r <= '0;
            shift_r    <= {rxs_r, shift_r[7:1]};
            bit_idx_r  <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_r <= ST_PARITY;
`else
              state_r <= ST_STOP;
`endif
            end
          end else if (tick_s) begin
            tick_cnt_r <= tick_cnt_r + TCK_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick_s && tick_cnt_r == FULL_LAST) begin
            tick_cnt_r <= '0;
            par_bit_r  <= rxs_r;
            state_r    <= ST_STOP;
          end else if (tick_s) begin
            tick_cnt_r <= tick_cnt_r + TCK_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (tick_s && tick_cnt_r == FULL_LAST) begin
            tick_cnt_r <= '0;
            if (rxs_r) begin
              deliver_pend_r <= 1'b1;
`ifdef UART_RX_PARITY_EN
              par_bad_r      <= par_bit_r ^ even_parity(shift_r);
`endif
              state_r        <= ST_IDLE;
              busy_r         <= 1'b0;
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= ST_BRK;
            end
          end else if (tick_s) begin
            tick_cnt_r <= tick_cnt_r + TCK_W'(1);
          end
        end
        ST_BRK: begin
          if (rxs_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: accept a delivery when empty or being drained this cycle, else flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r   <= 8'h00;
      out_valid_r  <= 1'b0;
      overrun_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      overrun_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= deliver_pend_r & par_bad_r;
`endif
      if (deliver_pend_r) begin
        if (!out_valid_r || out_ready) begin
          out_data_r  <= shift_r;
          out_valid_r <= 1'b1;
        end else begin
          overrun_r   <= 1'b1;
        end
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at default parameters (104-clock bits).
module tb_uart_rx_frontend;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int BIT_CLKS = 104;
  localparam int PAR_ADJ  = PAR_EN ? BIT_CLKS : 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_rx_frontend dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  int   cyc = 0, rise_cnt = 0, rise_cyc = 0, vhi_cnt = 0;
  int   fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, pe_rise_cnt = 0;
  int   busy_rise_cyc = 0, busy_fall_cyc = 0;
  logic prev_v = 1'b0, prev_b = 1'b0;

  // Event monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (out_valid) vhi_cnt = vhi_cnt + 1;
    if (out_valid && !prev_v) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
      if (parity_err) pe_rise_cnt = pe_rise_cnt + 1;
    end
    if (busy && !prev_b) busy_rise_cyc = cyc;
    if (!busy && prev_b) busy_fall_cyc = cyc;
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun) ov_cnt = ov_cnt + 1;
    if (parity_err) pe_cnt = pe_cnt + 1;
    prev_v = out_valid;
    prev_b = busy;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit(par);
    send_bit(stop);
    rx = 1'b1;
  endtask

  int s0, r0, v0, f0, o0, p0, pr0, lat, bdur;
  logic [7:0] d;

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    out_ready = 1'b1;
    wait_clks(5);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Idle line
    wait_clks(2000);
    check("idle_data", out_data, 8'h00);
    check("idle_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_errs", {29'd0, frame_err, overrun, parity_err}, 0);

    // 0x55 with consumer ready
    d = 8'h55;
    r0 = rise_cnt; v0 = vhi_cnt; s0 = cyc;
    send_frame(d, ^d, 1'b1);
    wait_clks(200);
    lat  = rise_cyc - s0;
    bdur = busy_fall_cyc - busy_rise_cyc;
    check("b55_rises", rise_cnt - r0, 1);
    check("b55_data", out_data, 8'h55);
    check("b55_valid_cycles", vhi_cnt - v0, 1);
    check("b55_latency_ok", (lat >= 985 + PAR_ADJ && lat <= 1000 + PAR_ADJ) ? 1 : 0, 1);
    check("b55_busy_len_ok", (bdur >= 980 + PAR_ADJ && bdur <= 995 + PAR_ADJ) ? 1 : 0, 1);

    // 30-clock low glitch
    r0 = rise_cnt; f0 = fe_cnt; s0 = cyc;
    rx = 1'b0;
    wait_clks(30);
    rx = 1'b1;
    wait_clks(100);
    check("glitch_rises", rise_cnt - r0, 0);
    check("glitch_fe", fe_cnt - f0, 0);
    check("glitch_busy_drop", (busy_fall_cyc > s0 && busy_fall_cyc - s0 <= 60) ? 1 : 0, 1);
    check("glitch_busy", busy, 0);

    // 0xA3 with stop low, line held low for 3 bit times
    d = 8'hA3;
    r0 = rise_cnt; f0 = fe_cnt;
    send_frame(d, ^d, 1'b0);
    rx = 1'b0;
    wait_clks(2 * BIT_CLKS);
    rx = 1'b1;
    wait_clks(200);
    check("brk_fe", fe_cnt - f0, 1);
    check("brk_rises", rise_cnt - r0, 0);
    check("brk_busy", busy, 0);

    // 0x3C after the break
    d = 8'h3C;
    r0 = rise_cnt;
    send_frame(d, ^d, 1'b1);
    wait_clks(200);
    check("b3c_rises", rise_cnt - r0, 1);
    check("b3c_data", out_data, 8'h3C);

    // Overrun: consumer stalled
    out_ready = 1'b0;
    o0 = ov_cnt;
    d = 8'h11;
    send_frame(d, ^d, 1'b1);
    wait_clks(200);
    check("ovr_first_data", out_data, 8'h11);
    check("ovr_first_valid", out_valid, 1);
    d = 8'h22;
    send_frame(d, ^d, 1'b1);
    wait_clks(200);
    check("ovr_pulses", ov_cnt - o0, 1);
    check("ovr_data_kept", out_data, 8'h11);
    check("ovr_valid_kept", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_before_edge", out_valid, 1);
    @(negedge clk);
    check("ovr_valid_fell", out_valid, 0);
    wait_clks(10);

    if (PAR_EN) begin
      // 0x07 with bad parity bit (expected 1), then with correct parity
      r0 = rise_cnt; pr0 = pe_rise_cnt; p0 = pe_cnt;
      send_frame(8'h07, 1'b0, 1'b1);
      wait_clks(200);
      check("par_bad_rises", rise_cnt - r0, 1);
      check("par_bad_data", out_data, 8'h07);
      check("par_bad_pe_at_rise", pe_rise_cnt - pr0, 1);
      check("par_bad_pe_count", pe_cnt - p0, 1);
      p0 = pe_cnt; r0 = rise_cnt;
      send_frame(8'h07, 1'b1, 1'b1);
      wait_clks(200);
      check("par_ok_rises", rise_cnt - r0, 1);
      check("par_ok_pe", pe_cnt - p0, 0);
    end

    check("parity_err_total", pe_cnt, PAR_EN ? 1 : 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
